// File: rtl/oai_lane_pipe.sv
// rtl/oai_lane_pipe.sv - pipelined multi-lane OAI/OA function with valid/ready and delivered-result counter
//
// Purpose: WIDTH independent lanes each compute (|A_group) & B & C, optionally
// inverted (POL=0 gives OAI, POL=1 gives OA). Results pass through a DEPTH-stage
// valid/ready pipeline with a combinational ready chain. A saturating counter
// tracks output handshakes.
//
// Ports:
//   CLK        rising-edge clock
//   RN         synchronous active-low reset
//   A          OR-group inputs, lane k uses A[k*N_OR +: N_OR]
//   B, C       per-lane AND inputs
//   IN_VALID   input word valid
//   IN_READY   pipeline accepts the input word this cycle
//   ZN         per-lane result from the last stage
//   OUT_VALID  ZN holds a valid result
//   OUT_READY  downstream accepts ZN this cycle
//   CNT_CLR    synchronous clear of CNT (wins over a simultaneous increment)
//   CNT        saturating count of output handshakes
module oai_lane_pipe #(
  parameter int WIDTH = 4,
  parameter int N_OR  = 2,
  parameter int DEPTH = 2,
  parameter int POL   = 0,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RN,
  input  logic [WIDTH*N_OR-1:0]  A,
  input  logic [WIDTH-1:0]       B,
  input  logic [WIDTH-1:0]       C,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [WIDTH-1:0]       ZN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  input  logic                   CNT_CLR,
  output logic [CNT_W-1:0]       CNT
);

  // Reset data equals the lane result for all-zero inputs.
  localparam logic [WIDTH-1:0] RST_D = (POL != 0) ? '0 : '1;

  logic [WIDTH-1:0] w_lane;
  logic [DEPTH-1:0] w_rdy;
  logic             w_out_hs;

  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (POL != 0)
        w_lane[k] = (|A[k*N_OR +: N_OR]) & B[k] & C[k];
      else
        w_lane[k] = ~((|A[k*N_OR +: N_OR]) & B[k] & C[k]);
    end
  end

  // Stage i can advance if the output drains or any stage from i to the end
  // is empty; accumulated from the output side so no vector feeds itself.
  always_comb begin
    logic w_acc;
    w_rdy = '0;
    w_acc = OUT_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_acc    = w_acc | ~r_v[i];
      w_rdy[i] = w_acc;
    end
  end

  assign w_out_hs = r_v[DEPTH-1] & OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RST_D;
      end
      r_v   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_d[0] <= w_lane;
        r_v[0] <= IN_VALID;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_d[i] <= r_d[i-1];
          r_v[i] <= r_v[i-1];
        end
      end
      if (CNT_CLR)
        r_cnt <= '0;
      else if (w_out_hs && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign IN_READY  = w_rdy[0];
  assign ZN        = r_d[DEPTH-1];
  assign OUT_VALID = r_v[DEPTH-1];
  assign CNT       = r_cnt;

endmodule

// File: tb/tb_oai_lane_pipe.sv
// tb/tb_oai_lane_pipe.sv - directed self-checking bench for oai_lane_pipe
module tb_oai_lane_pipe;

  logic       CLK;
  logic       RN;
  logic [7:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic       IN_VALID;
  logic       OUT_READY;
  logic       CNT_CLR;

  logic       ir0, ov0, ir1, ov1, ir2, ov2;
  logic [3:0] zn0, zn1, zn2;
  logic [7:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int tests;
  int fails;

  oai_lane_pipe #(.WIDTH(4), .N_OR(2), .DEPTH(2), .POL(0), .CNT_W(8)) dut0 (
    .CLK(CLK), .RN(RN), .A(A), .B(B), .C(C), .IN_VALID(IN_VALID), .IN_READY(ir0),
    .ZN(zn0), .OUT_VALID(ov0), .OUT_READY(OUT_READY), .CNT_CLR(CNT_CLR), .CNT(cnt0));

  oai_lane_pipe #(.WIDTH(4), .N_OR(2), .DEPTH(2), .POL(1), .CNT_W(8)) dut1 (
    .CLK(CLK), .RN(RN), .A(A), .B(B), .C(C), .IN_VALID(IN_VALID), .IN_READY(ir1),
    .ZN(zn1), .OUT_VALID(ov1), .OUT_READY(OUT_READY), .CNT_CLR(CNT_CLR), .CNT(cnt1));

  oai_lane_pipe #(.WIDTH(4), .N_OR(2), .DEPTH(2), .POL(0), .CNT_W(3)) dut2 (
    .CLK(CLK), .RN(RN), .A(A), .B(B), .C(C), .IN_VALID(IN_VALID), .IN_READY(ir2),
    .ZN(zn2), .OUT_VALID(ov2), .OUT_READY(OUT_READY), .CNT_CLR(CNT_CLR), .CNT(cnt2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    RN = 1'b0;
    tick();
    RN = 1'b1;
  endtask

  // With A and C all ones and POL=0, ZN == ~B, so B = ~w selects result w.
  task automatic drive_word(input logic [3:0] w);
    A = 8'hFF;
    C = 4'hF;
    B = ~w;
  endtask

  logic [3:0] exp_tt [16];
  logic [3:0] wq [6];
  logic [3:0] v;
  int sent, rcvd;
  logic in_hs, out_hs;

  initial begin
    tests = 0;
    fails = 0;
    A = '0; B = '0; C = '0;
    IN_VALID = 1'b0; OUT_READY = 1'b0; CNT_CLR = 1'b0; RN = 1'b1;

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_zn_pol0", 32'(zn0), 32'hF);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_zn_pol1", 32'(zn1), 32'h0);

    // Truth table on lane 0: {A1,A2,B,C} = i; other lanes idle (result 1)
    OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      exp_tt[i] = {3'b111, ~((v[3] | v[2]) & v[1] & v[0])};
    end
    for (int j = 0; j <= 16; j++) begin
      if (j < 16) begin
        v = 4'(j);
        A = {6'b0, v[3:2]};
        B = {3'b0, v[1]};
        C = {3'b0, v[0]};
        IN_VALID = 1'b1;
      end else begin
        IN_VALID = 1'b0;
      end
      tick();
      if (j == 0) chk("tt_latency_not_early", 32'(ov0), 32'd0);
      else begin
        chk($sformatf("tt_valid_%0d", j - 1), 32'(ov0), 32'd1);
        chk($sformatf("tt_zn_%0d", j - 1), 32'(zn0), 32'(exp_tt[j-1]));
      end
    end
    // Hand-computed spot values: A=01,B=1,C=1 -> 4'hE ; A=00,B=1,C=1 -> 4'hF
    chk("tt_hand_0111", 32'(exp_tt[7]), 32'hE);
    chk("tt_hand_0011", 32'(exp_tt[3]), 32'hF);
    tick();
    chk("tt_drained", 32'(ov0), 32'd0);
    chk("tt_cnt16", 32'(cnt0), 32'd16);

    // Polarity
    do_reset();
    A = 8'h55; B = 4'hF; C = 4'hF; IN_VALID = 1'b1;
    tick();
    B = 4'h0;
    tick();
    IN_VALID = 1'b0;
    chk("pol1_all_true", 32'(zn1), 32'hF);
    chk("pol0_all_true", 32'(zn0), 32'h0);
    tick();
    chk("pol1_b_zero", 32'(zn1), 32'h0);
    chk("pol0_b_zero", 32'(zn0), 32'hF);

    // Back-pressure: two words fill the stalled pipe, then drain in order
    do_reset();
    for (int i = 0; i < 6; i++) wq[i] = 4'(i + 1);
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    drive_word(wq[0]);
    chk("bp_ready_w0", 32'(ir0), 32'd1);
    tick();
    drive_word(wq[1]);
    chk("bp_ready_w1", 32'(ir0), 32'd1);
    tick();
    drive_word(wq[2]);
    chk("bp_ready_full", 32'(ir0), 32'd0);
    chk("bp_head_valid", 32'(ov0), 32'd1);
    chk("bp_head_zn", 32'(zn0), 32'(wq[0]));
    tick();
    chk("bp_stall_ready", 32'(ir0), 32'd0);
    chk("bp_stall_zn", 32'(zn0), 32'(wq[0]));
    sent = 2;
    rcvd = 0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      OUT_READY = (cyc % 3 != 1);
      IN_VALID = (sent < 6);
      if (sent < 6) drive_word(wq[sent]);
      #1;
      in_hs  = IN_VALID & ir0;
      out_hs = ov0 & OUT_READY;
      if (out_hs) begin
        chk($sformatf("bp_order_%0d", rcvd), 32'(zn0), 32'(wq[rcvd]));
        rcvd++;
      end
      tick();
      if (in_hs) sent++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    chk("bp_received", 32'(rcvd), 32'd6);
    chk("bp_cnt", 32'(cnt0), 32'd6);
    chk("bp_empty", 32'(ov0), 32'd0);

    // Bubble fill
    do_reset();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    drive_word(4'h7);
    tick();
    IN_VALID = 1'b0;
    tick(); tick(); tick();
    IN_VALID = 1'b1;
    drive_word(4'h8);
    chk("bub_ready", 32'(ir0), 32'd1);
    tick();
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    chk("bub_w0_valid", 32'(ov0), 32'd1);
    chk("bub_w0_zn", 32'(zn0), 32'h7);
    tick();
    chk("bub_w1_valid", 32'(ov0), 32'd1);
    chk("bub_w1_zn", 32'(zn0), 32'h8);
    tick();
    chk("bub_empty", 32'(ov0), 32'd0);
    chk("bub_cnt", 32'(cnt0), 32'd2);

    // Counter saturation and clear priority
    do_reset();
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    drive_word(4'h3);
    for (int i = 0; i < 9; i++) tick();
    IN_VALID = 1'b0;
    tick(); tick();
    chk("cnt_sat3", 32'(cnt2), 32'd7);
    chk("cnt_full8", 32'(cnt0), 32'd9);
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    chk("clr_pre_valid", 32'(ov0), 32'd1);
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    chk("clr_cnt8", 32'(cnt0), 32'd0);
    chk("clr_cnt3", 32'(cnt2), 32'd0);

    // Reset mid-stream
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    drive_word(4'h0);
    tick();
    OUT_READY = 1'b0;
    tick();
    chk("mid_inflight", 32'(ov0), 32'd1);
    chk("mid_zn", 32'(zn0), 32'h0);
    IN_VALID = 1'b0;
    do_reset();
    chk("mid_rst_valid", 32'(ov0), 32'd0);
    chk("mid_rst_zn", 32'(zn0), 32'hF);
    chk("mid_rst_cnt", 32'(cnt0), 32'd0);
    chk("mid_rst_ready", 32'(ir0), 32'd1);
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    drive_word(4'h5);
    tick();
    IN_VALID = 1'b0;
    chk("mid_lat1", 32'(ov0), 32'd0);
    tick();
    chk("mid_lat2_valid", 32'(ov0), 32'd1);
    chk("mid_lat2_zn", 32'(zn0), 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
